// File: rtl/input_debouncer.sv
// input_debouncer: conditions a raw asynchronous level before it reaches the
// pulse stretcher. raw_in is synchronised into the clk domain. A change is
// accepted only after debounce_len+1 consecutive equal synchronised samples.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst           synchronous, active-high reset
//   raw_in        asynchronous raw input
//   debounce_len  extra stable samples required before accepting a change (N)
//   clean_out     debounced level (feeds the stretcher's `in` port)
//   rise_pulse    1-cycle strobe on the first high cycle of clean_out
//   fall_pulse    1-cycle strobe on the first low cycle of clean_out
//   busy          1 while a candidate edge is being qualified
//   glitch_cnt    (GLITCH_COUNT_EN only) saturating count of rejected candidates
//
// Optional feature macro: GLITCH_COUNT_EN
//
// Parameters
//   SYNC_STAGES   synchroniser depth on raw_in, legal 2..4
//   CNT_W         width of debounce_len and the stability counter

module input_debouncer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_in,
    input  logic [CNT_W-1:0] debounce_len,
    output logic             clean_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy
`ifdef GLITCH_COUNT_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       len_q;
    logic                   s;

    // Synchroniser chain; the FSM only ever looks at the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Qualification FSM. busy tracks "next state is a CHK_* state" so it is
    // registered alongside state. len_q is captured on entry to CHK_* so a
    // mid-qualification change of debounce_len only affects the next candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LO;
            cnt        <= '0;
            len_q      <= '0;
            clean_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
`ifdef GLITCH_COUNT_EN
            glitch_cnt <= 8'h00;
`endif
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                ST_LO: begin
                    if (s) begin
                        if (debounce_len == '0) begin
                            state      <= ST_HI;
                            clean_out  <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            state <= CHK_HI;
                            cnt   <= CNT_W'(1);
                            len_q <= debounce_len;
                            busy  <= 1'b1;
                        end
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state <= ST_LO;
                        busy  <= 1'b0;
`ifdef GLITCH_COUNT_EN
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`endif
                    end else if (cnt == len_q) begin
                        state      <= ST_HI;
                        busy       <= 1'b0;
                        clean_out  <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        if (debounce_len == '0) begin
                            state      <= ST_LO;
                            clean_out  <= 1'b0;
                            fall_pulse <= 1'b1;
                        end else begin
                            state <= CHK_LO;
                            cnt   <= CNT_W'(1);
                            len_q <= debounce_len;
                            busy  <= 1'b1;
                        end
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state <= ST_HI;
                        busy  <= 1'b0;
`ifdef GLITCH_COUNT_EN
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`endif
                    end else if (cnt == len_q) begin
                        state      <= ST_LO;
                        busy       <= 1'b0;
                        clean_out  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_LO;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (SYNC_STAGES=2, CNT_W=4).
// Edge numbering: edge 0 is the first posedge that samples a new raw_in value;
// outputs are sampled 1 time unit after each posedge.

module tb_input_debouncer;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             raw_in;
    logic [CNT_W-1:0] debounce_len;
    logic             clean_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             busy;
`ifdef GLITCH_COUNT_EN
    logic [7:0]       glitch_cnt;
`endif

    int errors = 0;
    int checks = 0;

    input_debouncer #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_in       (raw_in),
        .debounce_len (debounce_len),
        .clean_out    (clean_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .busy         (busy)
`ifdef GLITCH_COUNT_EN
        ,
        .glitch_cnt   (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new level with length n and check every output for ncyc edges.
    // Precondition: the debouncer is settled at ~level. Optionally change
    // debounce_len to chg_len right after edge chg_e has been checked.
    task automatic step_check(input string tag, input logic level, input int n,
                              input int ncyc, input int chg_e, input int chg_len);
        logic exp_clean;
        raw_in       = level;
        debounce_len = CNT_W'(n);
        for (int e = 0; e < ncyc; e++) begin
            tick();
            exp_clean = (e >= 2 + n) ? level : ~level;
            check({tag, ".clean"}, 32'(clean_out), 32'(exp_clean));
            check({tag, ".rise"},  32'(rise_pulse), 32'(level && (e == 2 + n)));
            check({tag, ".fall"},  32'(fall_pulse), 32'(!level && (e == 2 + n)));
            check({tag, ".busy"},  32'(busy), 32'((n > 0) && (e >= 2) && (e < 2 + n)));
            if (e == chg_e) debounce_len = CNT_W'(chg_len);
        end
    endtask

    initial begin
        rst          = 1'b1;
        raw_in       = 1'b1;
        debounce_len = CNT_W'(3);

        // Reset held 3 cycles with raw_in high: everything stays low.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.clean", 32'(clean_out), 32'd0);
            check("rst.rise",  32'(rise_pulse), 32'd0);
            check("rst.busy",  32'(busy), 32'd0);
        end
`ifdef GLITCH_COUNT_EN
        check("rst.glitch", 32'(glitch_cnt), 32'd0);
`endif
        rst = 1'b0;
        // After release clean_out rises at edge 2+N.
        step_check("rel", 1'b1, 3, 9, -1, 0);

        // Clean steps with N=3: fall then rise at edge 5.
        step_check("step_fall", 1'b0, 3, 9, -1, 0);
        step_check("step_rise", 1'b1, 3, 9, -1, 0);
        step_check("step_fall2", 1'b0, 3, 9, -1, 0);

        // Glitch: 3 high samples with N=3 is one short of acceptance.
        debounce_len = CNT_W'(3);
        for (int e = 0; e < 9; e++) begin
            raw_in = (e < 3) ? 1'b1 : 1'b0;
            tick();
            check("glitch.clean", 32'(clean_out), 32'd0);
            check("glitch.rise",  32'(rise_pulse), 32'd0);
            check("glitch.busy",  32'(busy), 32'((e >= 2) && (e <= 4)));
        end
`ifdef GLITCH_COUNT_EN
        check("glitch.cnt", 32'(glitch_cnt), 32'd1);
`endif

        // Bypass N=0: toggle every 4 cycles, output follows after 2 edges.
        step_check("byp1", 1'b1, 0, 4, -1, 0);
        step_check("byp0", 1'b0, 0, 4, -1, 0);
        step_check("byp1b", 1'b1, 0, 4, -1, 0);
        step_check("byp0b", 1'b0, 0, 4, -1, 0);

        // N=5 latched; debounce_len drops to 1 mid-CHK_HI, acceptance still at edge 7.
        step_check("lenchg", 1'b1, 5, 10, 3, 1);
        step_check("lennext", 1'b0, 1, 6, -1, 0);

        // Reset in the middle of CHK_HI.
        raw_in       = 1'b1;
        debounce_len = CNT_W'(3);
        for (int e = 0; e < 3; e++) tick();
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst.busy",  32'(busy), 32'd0);
        check("midrst.clean", 32'(clean_out), 32'd0);
        check("midrst.rise",  32'(rise_pulse), 32'd0);
        raw_in = 1'b0;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("postrst.clean", 32'(clean_out), 32'd0);
            check("postrst.rise",  32'(rise_pulse), 32'd0);
            check("postrst.busy",  32'(busy), 32'd0);
        end
`ifdef GLITCH_COUNT_EN
        check("midrst.glitch", 32'(glitch_cnt), 32'd0);
`endif

        // 300 glitches: 2 high samples then 3 low each, N=3.
        for (int g = 0; g < 300; g++) begin
            raw_in = 1'b1;
            tick();
            tick();
            raw_in = 1'b0;
            tick();
            tick();
            tick();
        end
        check("sat.clean", 32'(clean_out), 32'd0);
        check("sat.busy",  32'(busy), 32'd0);
`ifdef GLITCH_COUNT_EN
        check("sat.glitch", 32'(glitch_cnt), 32'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
